// File: rtl/cv32e40p_ft_pkg.sv
// Shared definitions for the TMR ALU fault-tracking logic.
//   NUM_ALU    : number of ALU replicas (three voted plus one spare).
//   alu_mask_t : one bit per ALU.
//   cnt_width  : width of a counter that must hold the value 0..threshold.
package cv32e40p_ft_pkg;

  localparam int unsigned NUM_ALU = 4;

  typedef logic [NUM_ALU-1:0] alu_mask_t;

  function automatic int unsigned cnt_width(input int unsigned threshold);
    return $clog2(threshold + 1);
  endfunction

endpackage

// File: rtl/cv32e40p_ft_sat_counter.sv
// Per-ALU error counter that saturates at THRESHOLD.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   inc_i    : one attributed error for this ALU this cycle
//   clr_i    : clear the count (overrides freeze)
//   freeze_i : ALU already declared faulty; the count holds
//   count_o  : current count
//   hit_o    : the value being loaded this cycle equals THRESHOLD
//              (computed before any clear, so a clear in the same
//              cycle does not hide a threshold crossing)
module cv32e40p_ft_sat_counter #(
  parameter int unsigned THRESHOLD = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] count_o,
  output logic             hit_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_inc;

  always_comb begin
    w_count_inc = r_count;
    if (inc_i && !freeze_i && (r_count != LIMIT)) begin
      w_count_inc = r_count + 1'b1;
    end
  end

  // Only a real step onto THRESHOLD counts as a hit.
  assign hit_o = (w_count_inc == LIMIT) && (r_count != LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_inc;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/cv32e40p_alu_fault_tracker.sv
// Permanent-fault tracker for the TMR ALU cluster. Attributes single
// voter mismatches to an ALU, counts them per ALU and latches a sticky
// faulty bit when a count reaches THRESHOLD.
//   clk_i                  : clock
//   rst_i                  : synchronous active-high reset
//   valid_i                : a voted ALU operation completes this cycle
//   err_alu_i              : per-ALU mismatch flags from the voter
//   active_alu_i           : ALUs currently in the TMR set
//   clear_i                : software clear of counters, window, faulty bits
//   permanent_faulty_alu_o : sticky faulty flags
//   new_fault_o            : pulse when any faulty bit goes 0->1
//   ambiguous_err_o        : pulse when >=2 masked errors are reported
//   err_count_o            : packed per-ALU counters, ALU0 in the LSBs
// Optional feature: define FT_ALU_FAULT_WINDOW_EN to clear non-frozen
// counters every WINDOW valid operations so transient upsets age out.
module cv32e40p_alu_fault_tracker
  import cv32e40p_ft_pkg::*;
#(
  parameter  int unsigned THRESHOLD = 4,
  parameter  int unsigned WINDOW    = 256,
  localparam int unsigned CNT_W     = cnt_width(THRESHOLD)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic [NUM_ALU-1:0]       err_alu_i,
  input  logic [NUM_ALU-1:0]       active_alu_i,
  input  logic                     clear_i,
  output logic [NUM_ALU-1:0]       permanent_faulty_alu_o,
  output logic                     new_fault_o,
  output logic                     ambiguous_err_o,
  output logic [NUM_ALU*CNT_W-1:0] err_count_o
);

  alu_mask_t r_faulty;
  logic      r_new_fault;
  logic      r_ambiguous;

  alu_mask_t w_masked;
  alu_mask_t w_inc;
  alu_mask_t w_clr;
  alu_mask_t w_hit;
  logic      w_multi;
  logic      w_single;
  logic      w_wrap;

  assign w_masked = err_alu_i & active_alu_i & ~r_faulty;
  // Clearing the lowest set bit leaves something only if >=2 bits were set.
  assign w_multi  = |(w_masked & (w_masked - 1'b1));
  assign w_single = (w_masked != '0) && !w_multi;
  assign w_inc    = (valid_i && w_single) ? w_masked : '0;

`ifdef FT_ALU_FAULT_WINDOW_EN
  localparam int unsigned WIN_W = $clog2(WINDOW);

  logic [WIN_W-1:0] r_win;

  assign w_wrap = valid_i && (r_win == WIN_W'(WINDOW - 1));

  // WINDOW is a power of two, so the increment wraps to 0 by itself.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_win <= '0;
    end else if (valid_i) begin
      r_win <= r_win + 1'b1;
    end
  end
`else
  logic w_unused_window;

  assign w_unused_window = (WINDOW == 0);
  assign w_wrap          = 1'b0;
`endif

  // Window wrap clears only counters of ALUs not already frozen; a counter
  // that hits THRESHOLD on the wrapping op still clears (its bit latches).
  assign w_clr = {NUM_ALU{clear_i}} | ({NUM_ALU{w_wrap}} & ~r_faulty);

  for (genvar g = 0; g < NUM_ALU; g++) begin : g_cnt
    cv32e40p_ft_sat_counter #(
      .THRESHOLD (THRESHOLD),
      .CNT_W     (CNT_W)
    ) u_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (w_inc[g]),
      .clr_i    (w_clr[g]),
      .freeze_i (r_faulty[g]),
      .count_o  (err_count_o[g*CNT_W +: CNT_W]),
      .hit_o    (w_hit[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_faulty    <= '0;
      r_new_fault <= 1'b0;
      r_ambiguous <= 1'b0;
    end else if (clear_i) begin
      r_faulty    <= '0;
      r_new_fault <= 1'b0;
      r_ambiguous <= 1'b0;
    end else begin
      r_faulty    <= r_faulty | w_hit;
      r_new_fault <= |(w_hit & ~r_faulty);
      r_ambiguous <= valid_i && w_multi;
    end
  end

  assign permanent_faulty_alu_o = r_faulty;
  assign new_fault_o            = r_new_fault;
  assign ambiguous_err_o        = r_ambiguous;

endmodule

// File: tb/tb_cv32e40p_alu_fault_tracker.sv
// Directed self-checking bench for cv32e40p_alu_fault_tracker
// (THRESHOLD=4, WINDOW=8). Expectations follow FT_ALU_FAULT_WINDOW_EN.
module tb_cv32e40p_alu_fault_tracker;

  localparam int unsigned CW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [3:0]    err_alu_i;
  logic [3:0]    active_alu_i;
  logic          clear_i;
  logic [3:0]    permanent_faulty_alu_o;
  logic          new_fault_o;
  logic          ambiguous_err_o;
  logic [4*CW-1:0] err_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  cv32e40p_alu_fault_tracker #(
    .THRESHOLD (4),
    .WINDOW    (8)
  ) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .valid_i                (valid_i),
    .err_alu_i              (err_alu_i),
    .active_alu_i           (active_alu_i),
    .clear_i                (clear_i),
    .permanent_faulty_alu_o (permanent_faulty_alu_o),
    .new_fault_o            (new_fault_o),
    .ambiguous_err_o        (ambiguous_err_o),
    .err_count_o            (err_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Apply inputs for one clock, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [3:0] e, input logic [3:0] a, input logic c);
    valid_i      = v;
    err_alu_i    = e;
    active_alu_i = a;
    clear_i      = c;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int unsigned i);
    return 32'(err_count_o[i*CW +: CW]);
  endfunction

  task automatic chk_all(input string tag, input logic [3:0] f, input logic nf,
                         input logic amb, input logic [4*CW-1:0] c);
    chk({tag, "_faulty"}, 32'(permanent_faulty_alu_o), 32'(f));
    chk({tag, "_newf"},   32'(new_fault_o),            32'(nf));
    chk({tag, "_amb"},    32'(ambiguous_err_o),        32'(amb));
    chk({tag, "_cnt"},    32'(err_count_o),            32'(c));
  endtask

  initial begin
    // Reset with errors present on every ALU
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'b1111, 4'b1111, 1'b0);
      chk_all("rst", 4'b0000, 1'b0, 1'b0, '0);
    end
    rst_i = 1'b0;
    cyc(1'b0, 4'b0000, 4'b0111, 1'b0);
    chk_all("post_rst", 4'b0000, 1'b0, 1'b0, '0);

    // Four errors on ALU1 reach THRESHOLD
    cyc(1'b1, 4'b0010, 4'b0111, 1'b0);
    chk("alu1_c1", cnt(1), 1);
    chk("alu1_f1", 32'(permanent_faulty_alu_o), 0);
    cyc(1'b1, 4'b0010, 4'b0111, 1'b0);
    chk("alu1_c2", cnt(1), 2);
    cyc(1'b1, 4'b0010, 4'b0111, 1'b0);
    chk("alu1_c3", cnt(1), 3);
    chk("alu1_nf3", 32'(new_fault_o), 0);
    cyc(1'b1, 4'b0010, 4'b0111, 1'b0);
    chk("alu1_c4", cnt(1), 4);
    chk("alu1_f4", 32'(permanent_faulty_alu_o), 32'h2);
    chk("alu1_nf4", 32'(new_fault_o), 1);
    cyc(1'b0, 4'b0000, 4'b0111, 1'b0);
    chk("alu1_nf_drop", 32'(new_fault_o), 0);
    chk("alu1_sticky", 32'(permanent_faulty_alu_o), 32'h2);
    cyc(1'b1, 4'b0010, 4'b0111, 1'b0);
    chk("alu1_frozen", cnt(1), 4);
    chk("alu1_no_renf", 32'(new_fault_o), 0);
    cyc(1'b0, 4'b0000, 4'b0111, 1'b1);
    chk_all("clr1", 4'b0000, 1'b0, 1'b0, '0);

    // Ambiguous and inactive-ALU errors
    cyc(1'b1, 4'b0011, 4'b0111, 1'b0);
    chk_all("amb", 4'b0000, 1'b0, 1'b1, '0);
    cyc(1'b0, 4'b0000, 4'b0111, 1'b0);
    chk("amb_drop", 32'(ambiguous_err_o), 0);
    cyc(1'b1, 4'b1000, 4'b0111, 1'b0);
    chk_all("inactive", 4'b0000, 1'b0, 1'b0, '0);
    cyc(1'b0, 4'b0011, 4'b0111, 1'b0);
    chk("amb_novalid", 32'(ambiguous_err_o), 0);
    cyc(1'b0, 4'b0000, 4'b0111, 1'b1);

    // Window ageing: 3 errors on ALU0, wrap, then a 4th error
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0001, 4'b0111, 1'b0);
    chk("win_c0_3", cnt(0), 3);
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'b0000, 4'b0111, 1'b0);
`ifdef FT_ALU_FAULT_WINDOW_EN
    chk("win_wrap_c0", cnt(0), 0);
`else
    chk("win_wrap_c0", cnt(0), 3);
`endif
    cyc(1'b1, 4'b0001, 4'b0111, 1'b0);
`ifdef FT_ALU_FAULT_WINDOW_EN
    chk_all("win_4th", 4'b0000, 1'b0, 1'b0, 12'(1));
`else
    chk_all("win_4th", 4'b0001, 1'b1, 1'b0, 12'(4));
`endif
    cyc(1'b0, 4'b0000, 4'b0111, 1'b1);

    // ALU2 reaches THRESHOLD on the last op of a window
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0100, 4'b0111, 1'b0);
    cyc(1'b1, 4'b0001, 4'b0111, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000, 4'b0111, 1'b0);
    chk("last_pre_c2", cnt(2), 3);
    chk("last_pre_c0", cnt(0), 1);
    cyc(1'b1, 4'b0100, 4'b0111, 1'b0);
`ifdef FT_ALU_FAULT_WINDOW_EN
    chk_all("last_op", 4'b0100, 1'b1, 1'b0, '0);
`else
    chk_all("last_op", 4'b0100, 1'b1, 1'b0, 12'h101);
`endif
    cyc(1'b0, 4'b0000, 4'b0111, 1'b1);

    // clear_i beats a threshold-reaching error and an ambiguous report
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0010, 4'b0111, 1'b0);
    chk("clr_pre_c1", cnt(1), 3);
    cyc(1'b1, 4'b0010, 4'b0111, 1'b1);
    chk_all("clr_hit", 4'b0000, 1'b0, 1'b0, '0);
    cyc(1'b1, 4'b0011, 4'b0111, 1'b1);
    chk("clr_amb", 32'(ambiguous_err_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
